// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } arb_state_t;

    // byte 0 is the most significant byte of the word
    typedef logic [0:3][7:0] mem_word_t;

    localparam int MAX_MEM_LATENCY = 15;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin pick between fetch and data
module rr_arbiter2 (
    input  logic i_req,
    input  logic d_req,
    input  logic last_d,
    output logic grant,
    output logic pick_d
);

    // Data wins when it is alone, or on a tie when fetch was served last.
    always_comb begin
        grant  = i_req | d_req;
        pick_d = d_req & (~i_req | ~last_d);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data requesters
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output mem_word_t   i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  mem_word_t   d_wdata,
    output logic        d_ack,
    output mem_word_t   d_rdata,
    output logic [31:0] mem_addr,
    output mem_word_t   mem_data_in,
    input  mem_word_t   mem_data_out,
    output logic        mem_write_en,
    output logic        busy,
    output logic        owner_d
);

    // Out-of-range latencies are clamped so the 4-bit counter can never wrap.
    localparam int LAT = (MEM_LATENCY < 1) ? 1 :
                         (MEM_LATENCY > MAX_MEM_LATENCY) ? MAX_MEM_LATENCY : MEM_LATENCY;
    localparam logic [3:0] LAST_CNT = 4'(LAT - 1);

    arb_state_t state, state_next;
    logic [3:0] cnt, cnt_next;
    logic       we_q, we_next;
    logic       last_d;
    logic       grant, pick_d;

    rr_arbiter2 u_rr (
        .i_req  (i_req),
        .d_req  (d_req),
        .last_d (last_d),
        .grant  (grant),
        .pick_d (pick_d)
    );

    // Next state, access counter and latched write flag.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        we_next    = we_q;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_next = BUSY;
                    cnt_next   = 4'd0;
                    we_next    = pick_d & d_we;
                end
            end
            BUSY: begin
                if (cnt == LAST_CNT) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register plus all registered outputs; write strobe and busy are
    // computed from next-state values so they line up with the cycle they describe.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            we_q         <= 1'b0;
            last_d       <= 1'b1;
            owner_d      <= 1'b0;
            busy         <= 1'b0;
            mem_write_en <= 1'b0;
            mem_addr     <= 32'd0;
            mem_data_in  <= '0;
            i_ack        <= 1'b0;
            d_ack        <= 1'b0;
            i_rdata      <= '0;
            d_rdata      <= '0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            we_q         <= we_next;
            busy         <= (state_next != IDLE);
            mem_write_en <= (state_next == BUSY) && (cnt_next == LAST_CNT) && we_next;
            i_ack        <= 1'b0;
            d_ack        <= 1'b0;

            if (state == IDLE && grant) begin
                mem_addr <= word_align(pick_d ? d_addr : i_addr);
                if (pick_d) begin
                    mem_data_in <= d_wdata;
                end
                owner_d <= pick_d;
                last_d  <= pick_d;
            end

            if (state == BUSY && cnt == LAST_CNT) begin
                if (owner_d) begin
                    d_ack <= 1'b1;
                    if (!we_q) begin
                        d_rdata <= mem_data_out;
                    end
                end else begin
                    i_ack <= 1'b1;
                    if (!we_q) begin
                        i_rdata <= mem_data_out;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        bit          is_d;
        logic [31:0] i_rd;
        logic [31:0] d_rd;
        int          cyc;
    } exp_ack_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_wr_t;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr;
    mem_word_t   d_wdata, i_rdata, d_rdata, mem_data_in, mem_data_out;
    logic        i_ack, d_ack, mem_write_en, busy, owner_d;
    logic [31:0] mem_addr;

    logic        rst1, i1_req, i1_ack, d1_ack, mem1_we, busy1, owner1;
    logic [31:0] i1_addr, mem1_addr;
    mem_word_t   i1_rdata, d1_rdata, mem1_din, mem1_dout;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_i, exp_d;
    exp_ack_t ack_q[$];
    exp_wr_t  wr_q[$];
    exp_ack_t mon_a;
    exp_wr_t  mon_w;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mem_data_out = (mem_addr == 32'h10) ? 32'hDEADBEEF : (mem_addr ^ 32'hA5A5_0000);
    assign mem1_dout    = mem1_addr ^ 32'hA5A5_0000;

    mem_port_arbiter #(.MEM_LATENCY(4)) dut (
        .clk(clk), .rst_b(rst_b),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_write_en(mem_write_en), .busy(busy), .owner_d(owner_d)
    );

    mem_port_arbiter #(.MEM_LATENCY(1)) dut1 (
        .clk(clk), .rst_b(rst1),
        .i_req(i1_req), .i_addr(i1_addr), .i_ack(i1_ack), .i_rdata(i1_rdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'd0), .d_wdata(32'd0),
        .d_ack(d1_ack), .d_rdata(d1_rdata),
        .mem_addr(mem1_addr), .mem_data_in(mem1_din), .mem_data_out(mem1_dout),
        .mem_write_en(mem1_we), .busy(busy1), .owner_d(owner1)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check32({tag, "_i_ack"}, {31'd0, i_ack}, 32'd0);
        check32({tag, "_d_ack"}, {31'd0, d_ack}, 32'd0);
        check32({tag, "_i_rdata"}, i_rdata, 32'd0);
        check32({tag, "_d_rdata"}, d_rdata, 32'd0);
        check32({tag, "_mem_addr"}, mem_addr, 32'd0);
        check32({tag, "_mem_data_in"}, mem_data_in, 32'd0);
        check32({tag, "_mem_write_en"}, {31'd0, mem_write_en}, 32'd0);
        check32({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check32({tag, "_owner_d"}, {31'd0, owner_d}, 32'd0);
    endtask

    task automatic push_ack(input bit is_d, input int at);
        exp_ack_t e;
        e.is_d = is_d;
        e.i_rd = exp_i;
        e.d_rd = exp_d;
        e.cyc  = at;
        ack_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while ((ack_q.size() != 0 || wr_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check32({name, "_timeout"}, 32'(ack_q.size()), 32'd0);
        tick();
    endtask

    // Requesters drop their request at the edge that ends their ack cycle.
    always @(negedge clk) begin
        if (i_ack) i_req = 1'b0;
        if (d_ack) d_req = 1'b0;
    end

    // Monitor: pop and compare whenever an ack or a write strobe appears.
    always @(negedge clk) begin
        if (i_ack || d_ack) begin
            if (ack_q.size() == 0) begin
                check32("unexpected_ack", {30'd0, i_ack, d_ack}, 32'd0);
            end else begin
                mon_a = ack_q.pop_front();
                check32("ack_sel", {30'd0, i_ack, d_ack}, mon_a.is_d ? 32'd1 : 32'd2);
                check32("ack_owner_d", {31'd0, owner_d}, {31'd0, mon_a.is_d});
                check32("ack_cycle", 32'(cyc), 32'(mon_a.cyc));
                check32("ack_i_rdata", i_rdata, mon_a.i_rd);
                check32("ack_d_rdata", d_rdata, mon_a.d_rd);
            end
        end
        if (mem_write_en) begin
            if (wr_q.size() == 0) begin
                check32("unexpected_write", {31'd0, mem_write_en}, 32'd0);
            end else begin
                mon_w = wr_q.pop_front();
                check32("wr_addr", mem_addr, mon_w.addr);
                check32("wr_data", mem_data_in, mon_w.data);
                check32("wr_cycle", 32'(cyc), 32'(mon_w.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        int k;
        int n;
        exp_wr_t w;
        i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
        i1_req = 0; i1_addr = 0;
        rst_b = 1; rst1 = 1;
        exp_i = 0; exp_d = 0;
        repeat (3) tick();
        check_reset_vals("reset");
        rst_b = 0; rst1 = 0;
        tick();

        // single fetch
        i_addr = 32'h13; i_req = 1; k = cyc;
        exp_i = 32'hDEADBEEF;
        push_ack(0, k + 5);
        repeat (2) @(negedge clk);
        check32("fetch_mem_addr", mem_addr, 32'h10);
        check32("fetch_busy", {31'd0, busy}, 32'd1);
        wait_drain("fetch", 20);

        // data write
        d_we = 1; d_addr = 32'h40; d_wdata = 32'h11223344; d_req = 1; k = cyc;
        w.addr = 32'h40; w.data = 32'h11223344; w.cyc = k + 4;
        wr_q.push_back(w);
        push_ack(1, k + 5);
        wait_drain("write", 20);
        d_we = 0;

        // data read
        d_addr = 32'h44; d_req = 1; k = cyc;
        exp_d = 32'hA5A50044;
        push_ack(1, k + 5);
        wait_drain("dread", 20);

        // tie out of reset: fetch, data, fetch
        rst_b = 1; tick(); rst_b = 0;
        exp_i = 0; exp_d = 0;
        tick();
        i_addr = 32'h100; d_addr = 32'h200; i_req = 1; d_req = 1; k = cyc;
        exp_i = 32'hA5A50100;
        push_ack(0, k + 5);
        exp_d = 32'hA5A50200;
        push_ack(1, k + 11);
        push_ack(0, k + 17);
        n = 0;
        @(negedge clk);
        while (!i_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check32("tie_first_ack_timeout", 32'd0, 32'd1);
        tick();
        i_req = 1;
        wait_drain("tie", 40);

        // data arrives during fetch BUSY
        i_addr = 32'h20; i_req = 1; k = cyc;
        exp_i = 32'hA5A50020;
        push_ack(0, k + 5);
        repeat (2) tick();
        d_addr = 32'h24; d_req = 1;
        exp_d = 32'hA5A50024;
        push_ack(1, k + 11);
        wait_drain("late_d", 30);

        // reset in the 3rd BUSY cycle of a write
        d_we = 1; d_addr = 32'h80; d_wdata = 32'hCAFEF00D; d_req = 1; k = cyc;
        repeat (3) tick();
        check32("midrst_busy_before", {31'd0, busy}, 32'd1);
        rst_b = 1; d_req = 0; d_we = 0;
        tick();
        check_reset_vals("midrst");
        rst_b = 0;
        exp_i = 0; exp_d = 0;
        repeat (3) tick();
        d_addr = 32'h84; d_req = 1; k = cyc;
        exp_d = 32'hA5A50084;
        push_ack(1, k + 5);
        wait_drain("post_rst", 20);

        // MEM_LATENCY = 1 instance
        i1_addr = 32'h30; i1_req = 1; k = cyc;
        n = 0;
        @(negedge clk);
        while (!i1_ack && n < 10) begin
            @(negedge clk);
            n++;
        end
        i1_req = 0;
        check32("lat1_ack_delay", 32'(cyc - k), 32'd2);
        check32("lat1_rdata", i1_rdata, 32'hA5A50030);
        check32("lat1_d_ack", {31'd0, d1_ack}, 32'd0);

        repeat (4) tick();
        check32("ack_queue_empty", 32'(ack_q.size()), 32'd0);
        check32("wr_queue_empty", 32'(wr_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
